// File: rtl/uart_frame_writer_pkg.sv
// Shared definitions for the UART frame writer: FSM states, default SYNC byte,
// CRC-8 polynomial and the byte-wise CRC update used when FRAME_CRC8_EN is set.
package uart_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY    = 8'h07;

  // CRC-8, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_writer_if.sv
// Byte-in / UART-out signal bundle of the frame writer.
// slave  : the frame writer itself
// master : capture logic + UART side driving/observing the writer
interface uart_frame_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] tx_data;
  logic       send_data;
  logic       tx_full;
  logic       busy;

  modport slave (
    input  in_data, in_valid, flush, tx_full,
    output in_ready, tx_data, send_data, busy
  );

  modport master (
    output in_data, in_valid, flush, tx_full,
    input  in_ready, tx_data, send_data, busy
  );
endinterface

// File: rtl/uart_frame_writer_checksum.sv
// Running frame check byte over payload bytes.
// FRAME_CRC8_EN defined  : CRC-8 (poly 0x07, init 0x00).
// FRAME_CRC8_EN undefined: XOR of payload bytes.
module frame_checksum
  import uart_frame_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [7:0] result
);

  logic [7:0] sum_q, sum_d;

  // next check value: clear wins, otherwise fold in the accepted byte
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (en) begin
`ifdef FRAME_CRC8_EN
      sum_d = crc8_update(sum_q, data_in);
`else
      sum_d = sum_q ^ data_in;
`endif
    end
  end

  // check value register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign result = sum_q;

endmodule

// File: rtl/uart_frame_writer.sv
// UART frame writer: buffers captured bytes and emits SYNC, LEN, payload, CHK
// into the UART Tx FIFO, one write per two cycles at most, stalling on tx_full.
// Check byte type selected by FRAME_CRC8_EN (see frame_checksum).
module uart_frame_writer
  import uart_frame_writer_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1200,
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  uart_frame_writer_if.slave bus
);

  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  idx_q,   idx_d;
  logic [31:0] timer_q, timer_d;
  logic        gap_q,   gap_d;
  logic [7:0]  buf_q [MAX_LEN];
  logic [7:0]  buf_d [MAX_LEN];

  logic        accept;
  logic        send;
  logic [7:0]  tx_byte;
  logic        cs_clear;
  logic [7:0]  cs_result;

  assign accept = (state_q == ST_FILL) && bus.in_valid;

  frame_checksum u_checksum (
    .clk     (clk),
    .rst     (rst),
    .clear   (cs_clear),
    .en      (accept),
    .data_in (bus.in_data),
    .result  (cs_result)
  );

  // next-state, buffer fill and UART write strobe generation
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    gap_d    = 1'b0;
    buf_d    = buf_q;
    send     = 1'b0;
    tx_byte  = '0;
    cs_clear = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          buf_d[count_q[AW-1:0]] = bus.in_data;
          count_d                = count_q + 8'd1;
          timer_d                = '0;
        end else if (count_q != 8'd0 && timer_q < TIMEOUT) begin
          timer_d = timer_q + 32'd1;
        end
        if ((count_d == MAX_LEN_B) ||
            (bus.flush && count_d != 8'd0) ||
            ((TIMEOUT != 0) && count_q != 8'd0 && timer_q == TIMEOUT)) begin
          state_d = ST_HDR;
          idx_d   = '0;
        end
      end
      ST_HDR: begin
        tx_byte = SYNC;
        if (!gap_q && !bus.tx_full) begin
          send    = 1'b1;
          gap_d   = 1'b1;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        tx_byte = count_q;
        if (!gap_q && !bus.tx_full) begin
          send    = 1'b1;
          gap_d   = 1'b1;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        tx_byte = buf_q[idx_q[AW-1:0]];
        if (!gap_q && !bus.tx_full) begin
          send  = 1'b1;
          gap_d = 1'b1;
          if (idx_q == count_q - 8'd1) state_d = ST_CHK;
          else                         idx_d   = idx_q + 8'd1;
        end
      end
      ST_CHK: begin
        tx_byte = cs_result;
        if (!gap_q && !bus.tx_full) begin
          send     = 1'b1;
          gap_d    = 1'b1;
          state_d  = ST_FILL;
          count_d  = '0;
          timer_d  = '0;
          cs_clear = 1'b1;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // state, counters and payload buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      count_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      gap_q   <= 1'b0;
      buf_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.busy      = (state_q != ST_FILL);
  assign bus.send_data = send;
  assign bus.tx_data   = tx_byte;

endmodule

// File: tb/tb_uart_frame_writer.sv
// Self-checking bench for uart_frame_writer (XOR or CRC-8 check byte per
// FRAME_CRC8_EN); expected frames come from a byte-list reference model.
module tb_uart_frame_writer;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_writer_if bus_a();
  uart_frame_writer_if bus_b();

  uart_frame_writer #(.MAX_LEN(16), .TIMEOUT(20), .SYNC(8'hA5)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  uart_frame_writer #(.MAX_LEN(16), .TIMEOUT(0), .SYNC(8'hA5)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  cap_a[$];
  int unsigned capt_a[$];
  logic [7:0]  cap_b[$];
  int unsigned viol_full = 0, viol_gap = 0, viol_busy = 0;
  logic prev_send = 1'b0;

  // UART-side monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus_a.send_data === 1'b1) begin
      cap_a.push_back(bus_a.tx_data);
      capt_a.push_back(cyc);
      if (bus_a.tx_full) viol_full++;
      if (prev_send) viol_gap++;
      if (!bus_a.busy) viol_busy++;
    end
    if (bus_a.busy === bus_a.in_ready) viol_busy++;
    prev_send = bus_a.send_data;
    if (bus_b.send_data === 1'b1) cap_b.push_back(bus_b.tx_data);
  end

  // reference check byte: bit-serial CRC-8 or XOR over payload
  function automatic logic [7:0] model_chk(input bq_t p);
    logic [7:0] c;
    logic [7:0] d;
    logic fb;
    c = 8'h00;
    foreach (p[i]) begin
      d = p[i];
`ifdef FRAME_CRC8_EN
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ d[j];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
`else
      fb = 1'b0;
      c  = c ^ d;
`endif
    end
    return c;
  endfunction

  function automatic bq_t frame_of(input bq_t p);
    bq_t f;
    f.push_back(8'hA5);
    f.push_back(8'(p.size()));
    foreach (p[i]) f.push_back(p[i]);
    f.push_back(model_chk(p));
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one byte until the handshake completes; acc = edge number of acceptance
  task automatic push_byte(input logic [7:0] b, input logic fl, output int unsigned acc);
    logic rdy;
    bit ok;
    ok = 1'b0;
    bus_a.in_data  = b;
    bus_a.in_valid = 1'b1;
    bus_a.flush    = fl;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      rdy = bus_a.in_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    acc = cyc;
    bus_a.in_valid = 1'b0;
    bus_a.flush    = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_%h: byte not accepted within 2000 cycles", b);
    end
  endtask

  task automatic flush_pulse(output int unsigned trig);
    bus_a.flush = 1'b1;
    tick();
    trig = cyc;
    bus_a.flush = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget, input string name);
    for (int k = 0; k < budget && cap_a.size() < n; k++) tick();
    n_chk++;
    if (cap_a.size() < n) begin
      n_fail++;
      $display("FAIL %s_wait: got %0d bytes, expected %0d", name, cap_a.size(), n);
    end
  endtask

  task automatic clear_caps();
    cap_a.delete();
    capt_a.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.flush = 1'b0; bus_a.tx_full = 1'b0;
    bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.flush = 1'b0; bus_b.tx_full = 1'b0;
    repeat (3) tick();
    n_chk++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", bus_a.in_ready); end
    n_chk++; if (bus_a.send_data !== 1'b0) begin n_fail++; $display("FAIL rst_send: got %b expected 0", bus_a.send_data); end
    n_chk++; if (bus_a.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", bus_a.tx_data); end
    n_chk++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus_a.busy); end
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_flush_partial();
    bq_t p, e;
    int unsigned acc, trig, busy_low;
    p = '{8'hAA, 8'h55, 8'h0F};
    e = frame_of(p);
    clear_caps();
    foreach (p[i]) push_byte(p[i], 1'b0, acc);
    tick();
    flush_pulse(trig);
    busy_low = 0;
    for (int k = 0; k < 40 && cap_a.size() < e.size(); k++) begin
      @(negedge clk);
      if (!bus_a.busy || bus_a.in_ready) busy_low++;
      tick();
    end
    n_chk++; if (cap_a.size() != e.size()) begin n_fail++; $display("FAIL flush_len: got %0d expected %0d", cap_a.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++;
      if (i >= cap_a.size() || cap_a[i] !== e[i]) begin
        n_fail++; $display("FAIL flush_byte[%0d]: got %h expected %h", i, (i < cap_a.size()) ? cap_a[i] : 8'hxx, e[i]);
      end
    end
    n_chk++; if (capt_a.size() == 0 || capt_a[0] != trig) begin n_fail++; $display("FAIL flush_latency: first write at %0d expected %0d", (capt_a.size() > 0) ? capt_a[0] : 0, trig); end
    for (int i = 1; i < capt_a.size(); i++) begin
      n_chk++;
      if (capt_a[i] - capt_a[i-1] != 2) begin n_fail++; $display("FAIL flush_spacing[%0d]: got %0d expected 2", i, capt_a[i] - capt_a[i-1]); end
    end
    n_chk++; if (busy_low != 0) begin n_fail++; $display("FAIL flush_busy: %0d cycles not busy, expected 0", busy_low); end
    repeat (3) tick();
  endtask

  task automatic test_full_frame();
    bq_t p, e;
    int unsigned acc;
    for (int i = 0; i < 16; i++) p.push_back(8'(i));
    e = frame_of(p);
    clear_caps();
    foreach (p[i]) push_byte(p[i], 1'b0, acc);
    wait_caps(e.size(), 60, "full");
    for (int i = 0; i < e.size(); i++) begin
      n_chk++;
      if (i >= cap_a.size() || cap_a[i] !== e[i]) begin
        n_fail++; $display("FAIL full_byte[%0d]: got %h expected %h", i, (i < cap_a.size()) ? cap_a[i] : 8'hxx, e[i]);
      end
    end
    n_chk++; if (capt_a.size() == 0 || capt_a[0] != acc) begin n_fail++; $display("FAIL full_latency: first write at %0d expected %0d", (capt_a.size() > 0) ? capt_a[0] : 0, acc); end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    bq_t p, e;
    int unsigned acc, trig;
    p = '{8'h7E};
    e = frame_of(p);
    clear_caps();
    push_byte(8'h7E, 1'b0, acc);
    wait_caps(e.size(), 60, "timeout");
    n_chk++; if (capt_a.size() == 0 || capt_a[0] != acc + 21) begin n_fail++; $display("FAIL timeout_start: first write at %0d expected %0d", (capt_a.size() > 0) ? capt_a[0] : 0, acc + 21); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++;
      if (i >= cap_a.size() || cap_a[i] !== e[i]) begin
        n_fail++; $display("FAIL timeout_byte[%0d]: got %h expected %h", i, (i < cap_a.size()) ? cap_a[i] : 8'hxx, e[i]);
      end
    end
    // TIMEOUT=0 instance: only a flush releases the frame
    cap_b.delete();
    bus_b.in_data = 8'h7E; bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    repeat (100) tick();
    n_chk++; if (cap_b.size() != 0) begin n_fail++; $display("FAIL notimeout_idle: got %0d bytes expected 0", cap_b.size()); end
    bus_b.flush = 1'b1;
    tick();
    trig = cyc;
    bus_b.flush = 1'b0;
    for (int k = 0; k < 40 && cap_b.size() < e.size(); k++) tick();
    n_chk++; if (cap_b.size() != e.size()) begin n_fail++; $display("FAIL notimeout_len: got %0d expected %0d (flush at %0d)", cap_b.size(), e.size(), trig); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++;
      if (i >= cap_b.size() || cap_b[i] !== e[i]) begin
        n_fail++; $display("FAIL notimeout_byte[%0d]: got %h expected %h", i, (i < cap_b.size()) ? cap_b[i] : 8'hxx, e[i]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    bq_t p, e, e2, q1;
    int unsigned acc, trig, stall_bad, sz_at_acc;
    logic [7:0] held;
    for (int i = 0; i < 5; i++) p.push_back(8'($urandom));
    e = frame_of(p);
    q1 = '{8'h99};
    e2 = frame_of(q1);
    clear_caps();
    foreach (p[i]) push_byte(p[i], 1'b0, acc);
    flush_pulse(trig);
    wait_caps(2, 20, "bp_len");
    bus_a.tx_full = 1'b1;
    stall_bad = 0;
    @(negedge clk);
    held = bus_a.tx_data;
    for (int k = 0; k < 50; k++) begin
      if (bus_a.send_data !== 1'b0) stall_bad++;
      if (bus_a.tx_data !== held) stall_bad++;
      @(negedge clk);
    end
    n_chk++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall: %0d bad cycles expected 0", stall_bad); end
    n_chk++; if (held !== p[0]) begin n_fail++; $display("FAIL bp_held: got %h expected %h", held, p[0]); end
    n_chk++; if (cap_a.size() != 2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", cap_a.size()); end
    tick();
    bus_a.tx_full = 1'b0;
    push_byte(8'h99, 1'b0, acc);
    sz_at_acc = cap_a.size();
    n_chk++; if (sz_at_acc != e.size()) begin n_fail++; $display("FAIL bp_holdoff: %0d bytes written at accept, expected %0d", sz_at_acc, e.size()); end
    n_chk++; if (capt_a.size() < e.size() || acc <= capt_a[e.size()-1]) begin n_fail++; $display("FAIL bp_accept_time: accepted at %0d, must follow CHK write", acc); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++;
      if (i >= cap_a.size() || cap_a[i] !== e[i]) begin
        n_fail++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, (i < cap_a.size()) ? cap_a[i] : 8'hxx, e[i]);
      end
    end
    flush_pulse(trig);
    wait_caps(e.size() + e2.size(), 40, "bp_next");
    for (int i = 0; i < e2.size(); i++) begin
      n_chk++;
      if (e.size() + i >= cap_a.size() || cap_a[e.size()+i] !== e2[i]) begin
        n_fail++; $display("FAIL bp_next_byte[%0d]: got %h expected %h", i, (e.size() + i < cap_a.size()) ? cap_a[e.size()+i] : 8'hxx, e2[i]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_midframe();
    bq_t p, e;
    int unsigned acc, trig;
    for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
    clear_caps();
    foreach (p[i]) push_byte(p[i], 1'b0, acc);
    flush_pulse(trig);
    wait_caps(3, 20, "mid_pay");
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_chk++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 1", bus_a.in_ready); end
    n_chk++; if (bus_a.send_data !== 1'b0) begin n_fail++; $display("FAIL mid_rst_send: got %b expected 0", bus_a.send_data); end
    n_chk++; if (bus_a.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx_data: got %h expected 00", bus_a.tx_data); end
    n_chk++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", bus_a.busy); end
    tick();
    rst = 1'b1;
    clear_caps();
    tick();
    p = '{8'h01};
    e = frame_of(p);
    push_byte(8'h01, 1'b0, acc);
    flush_pulse(trig);
    wait_caps(e.size(), 30, "mid_next");
    repeat (20) tick();
    n_chk++; if (cap_a.size() != e.size()) begin n_fail++; $display("FAIL mid_next_len: got %0d expected %0d", cap_a.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++;
      if (i >= cap_a.size() || cap_a[i] !== e[i]) begin
        n_fail++; $display("FAIL mid_next_byte[%0d]: got %h expected %h", i, (i < cap_a.size()) ? cap_a[i] : 8'hxx, e[i]);
      end
    end
  endtask

  task automatic test_check_vector();
    bq_t p, e;
    int unsigned acc, trig;
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    e = frame_of(p);
    clear_caps();
    foreach (p[i]) push_byte(p[i], 1'b0, acc);
    flush_pulse(trig);
    wait_caps(e.size(), 60, "vec");
    for (int i = 0; i < e.size(); i++) begin
      n_chk++;
      if (i >= cap_a.size() || cap_a[i] !== e[i]) begin
        n_fail++; $display("FAIL vec_byte[%0d]: got %h expected %h", i, (i < cap_a.size()) ? cap_a[i] : 8'hxx, e[i]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_random_frames();
    bq_t p, e;
    int unsigned acc, trig, len, mode;
    for (int f = 0; f < 8; f++) begin
      p.delete();
      len  = $urandom_range(1, 16);
      mode = $urandom_range(0, 1);
      for (int unsigned i = 0; i < len; i++) p.push_back(8'($urandom));
      e = frame_of(p);
      clear_caps();
      for (int unsigned i = 0; i < len; i++)
        push_byte(p[i], (i == len - 1) && (len < 16) && (mode == 0), acc);
      if (len < 16 && mode == 1) flush_pulse(trig);
      for (int k = 0; k < 400 && cap_a.size() < e.size(); k++) begin
        bus_a.tx_full = ($urandom_range(0, 2) == 0);
        tick();
      end
      bus_a.tx_full = 1'b0;
      n_chk++; if (cap_a.size() != e.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d expected %0d", f, cap_a.size(), e.size()); end
      for (int i = 0; i < e.size(); i++) begin
        n_chk++;
        if (i >= cap_a.size() || cap_a[i] !== e[i]) begin
          n_fail++; $display("FAIL rand%0d_byte[%0d]: got %h expected %h", f, i, (i < cap_a.size()) ? cap_a[i] : 8'hxx, e[i]);
        end
      end
      repeat (2) tick();
    end
  endtask

  task automatic test_protocol();
    n_chk++; if (viol_full != 0) begin n_fail++; $display("FAIL proto_full: %0d writes while tx_full, expected 0", viol_full); end
    n_chk++; if (viol_gap != 0) begin n_fail++; $display("FAIL proto_gap: %0d back-to-back writes, expected 0", viol_gap); end
    n_chk++; if (viol_busy != 0) begin n_fail++; $display("FAIL proto_busy: %0d busy/in_ready violations, expected 0", viol_busy); end
  endtask

  initial begin
    test_reset();
    test_flush_partial();
    test_full_frame();
    test_timeout();
    test_backpressure();
    test_reset_midframe();
    test_check_vector();
    test_random_frames();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
